// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug dumper.
// Holds the dumper FSM state encoding, the frame header/trailer bytes and
// the derived snapshot/frame size constants for the default core widths.
package mips_debug_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SNAP,
    S_HDR,
    S_LATCH,
    S_REG_ADDR,
    S_REG_WAIT,
    S_REG_SEND,
    S_MEM_ADDR,
    S_MEM_WAIT,
    S_MEM_SEND,
    S_TRL,
    S_DONE
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] TRL_BYTE = 8'h5A;

  // Total snapshot width from the four latch bus widths.
  function automatic int snap_bits(input int if_id, input int id_ex,
                                   input int ex_mem, input int mem_wb);
    return if_id + id_ex + ex_mem + mem_wb;
  endfunction

  localparam int NB_SNAP_DEF     = snap_bits(96, 160, 128, 96);
  localparam int SNAP_BYTES_DEF  = NB_SNAP_DEF / 8;
  localparam int FRAME_BYTES_DEF = 1 + SNAP_BYTES_DEF + 16 * 4 + 8 * 4 + 1;

endpackage

// File: rtl/debug_byte_serializer.sv
// Loads a W-bit word and shifts it out as W/8 bytes, MSB first, over a
// valid/ready stream. 'last' is high in the cycle the final byte transfers.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load, word      load request (taken only while idle) and word to send
//   ready           downstream ready
//   data, valid     current byte and stream valid
//   last            final byte of the word transfers this cycle
module debug_byte_serializer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         ready,
  output logic [7:0]   data,
  output logic         valid,
  output logic         last
);

  localparam int NB = W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load && !valid) begin
      sh    <= word;
      cnt   <= CW'(NB - 1);
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (cnt == '0) begin
        valid <= 1'b0;
      end else begin
        sh  <= sh << 8;
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign data = sh[W-1 -: 8];
  assign last = valid && ready && (cnt == '0);

endmodule

// File: rtl/mips_debug_dumper.sv
// Debug dumper for the pipelined MIPS core. On a start pulse (or a halt
// rising edge when auto mode is enabled) it snapshots the four inter-stage
// latch buses, then streams a byte frame:
//   0xA5, snapshot (MSB first), CANT_REG register words, CANT_MEM memory
//   words (each LEN/8 bytes MSB first), 0x5A.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_start, i_auto_en, i_halt   trigger sources
//   i_if_id..i_mem_wb            latch buses to snapshot
//   i_reg_data, i_mem_data       recolector read data
//   o_debug_flag, o_addr_reg/mem recolector control
//   o_tx_data/valid, i_tx_ready  byte stream
//   o_busy, o_done               frame status
module mips_debug_dumper
  import mips_debug_pkg::*;
#(
  parameter int LEN       = 32,
  parameter int NB_IF_ID  = 96,
  parameter int NB_ID_EX  = 160,
  parameter int NB_EX_MEM = 128,
  parameter int NB_MEM_WB = 96,
  parameter int CANT_REG  = 16,
  parameter int CANT_MEM  = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_auto_en,
  input  logic                        i_halt,
  input  logic [NB_IF_ID-1:0]         i_if_id,
  input  logic [NB_ID_EX-1:0]         i_id_ex,
  input  logic [NB_EX_MEM-1:0]        i_ex_mem,
  input  logic [NB_MEM_WB-1:0]        i_mem_wb,
  input  logic [LEN-1:0]              i_reg_data,
  input  logic [LEN-1:0]              i_mem_data,
  output logic                        o_debug_flag,
  output logic [$clog2(CANT_REG)-1:0] o_addr_reg,
  output logic [$clog2(CANT_MEM)-1:0] o_addr_mem,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int NB_SNAP = snap_bits(NB_IF_ID, NB_ID_EX, NB_EX_MEM, NB_MEM_WB);
  localparam int AR      = $clog2(CANT_REG);
  localparam int AM      = $clog2(CANT_MEM);
  localparam logic [AR-1:0] LAST_REG  = AR'(CANT_REG - 1);
  localparam logic [AM-1:0] LAST_MEM  = AM'(CANT_MEM - 1);
  localparam logic [1:0]    WAIT_INIT = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t             state;
  logic               halt_q;
  logic [NB_SNAP-1:0] snap;
  logic [1:0]         wcnt;

  logic               ld_b, ld_s, ld_w;
  logic [7:0]         b_in;
  logic [LEN-1:0]     w_in;
  logic [7:0]         b_data, s_data, w_data;
  logic               b_valid, s_valid, w_valid;
  logic               b_last, s_last, w_last;

  logic trig;
  assign trig = i_start | (i_auto_en & i_halt & ~halt_q);

  // Serializer loads are issued in the cycle before each section starts so
  // that sections follow each other without an idle byte slot.
  always_comb begin
    ld_b = 1'b0;
    b_in = HDR_BYTE;
    ld_s = 1'b0;
    ld_w = 1'b0;
    w_in = i_reg_data;
    case (state)
      S_SNAP:     ld_b = 1'b1;
      S_HDR:      ld_s = b_last;
      S_REG_ADDR: ld_w = (RD_LAT == 0);
      S_REG_WAIT: ld_w = (wcnt == 2'd0);
      S_MEM_ADDR: begin
        ld_w = (RD_LAT == 0);
        w_in = i_mem_data;
      end
      S_MEM_WAIT: begin
        ld_w = (wcnt == 2'd0);
        w_in = i_mem_data;
      end
      S_MEM_SEND: begin
        ld_b = w_last && (o_addr_mem == LAST_MEM);
        b_in = TRL_BYTE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      halt_q       <= 1'b0;
      snap         <= '0;
      wcnt         <= '0;
      o_debug_flag <= 1'b0;
      o_addr_reg   <= '0;
      o_addr_mem   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      halt_q <= i_halt;
      case (state)
        S_IDLE: if (trig) begin
          snap   <= {i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
          o_busy <= 1'b1;
          state  <= S_SNAP;
        end
        S_SNAP: state <= S_HDR;
        S_HDR:  if (b_last) state <= S_LATCH;
        S_LATCH: if (s_last) begin
          o_debug_flag <= 1'b1;
          o_addr_reg   <= '0;
          state        <= S_REG_ADDR;
        end
        S_REG_ADDR: begin
          wcnt  <= WAIT_INIT;
          state <= (RD_LAT == 0) ? S_REG_SEND : S_REG_WAIT;
        end
        S_REG_WAIT: begin
          if (wcnt == 2'd0) state <= S_REG_SEND;
          else              wcnt  <= wcnt - 2'd1;
        end
        S_REG_SEND: if (w_last) begin
          if (o_addr_reg == LAST_REG) begin
            o_addr_mem <= '0;
            state      <= S_MEM_ADDR;
          end else begin
            o_addr_reg <= o_addr_reg + 1'b1;
            state      <= S_REG_ADDR;
          end
        end
        S_MEM_ADDR: begin
          wcnt  <= WAIT_INIT;
          state <= (RD_LAT == 0) ? S_MEM_SEND : S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (wcnt == 2'd0) state <= S_MEM_SEND;
          else              wcnt  <= wcnt - 2'd1;
        end
        S_MEM_SEND: if (w_last) begin
          if (o_addr_mem == LAST_MEM) begin
            o_debug_flag <= 1'b0;
            state        <= S_TRL;
          end else begin
            o_addr_mem <= o_addr_mem + 1'b1;
            state      <= S_MEM_ADDR;
          end
        end
        S_TRL: if (b_last) begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  debug_byte_serializer #(.W(8)) u_byte (
    .clk(i_clk), .rst_n(i_rst), .load(ld_b), .word(b_in), .ready(i_tx_ready),
    .data(b_data), .valid(b_valid), .last(b_last)
  );

  debug_byte_serializer #(.W(NB_SNAP)) u_snap (
    .clk(i_clk), .rst_n(i_rst), .load(ld_s), .word(snap), .ready(i_tx_ready),
    .data(s_data), .valid(s_valid), .last(s_last)
  );

  debug_byte_serializer #(.W(LEN)) u_word (
    .clk(i_clk), .rst_n(i_rst), .load(ld_w), .word(w_in), .ready(i_tx_ready),
    .data(w_data), .valid(w_valid), .last(w_last)
  );

  // At most one serializer is active at a time.
  assign o_tx_valid = b_valid | s_valid | w_valid;
  assign o_tx_data  = ({8{b_valid}} & b_data) | ({8{s_valid}} & s_data) |
                      ({8{w_valid}} & w_data);

endmodule

// File: tb/tb_mips_debug_dumper.sv
module tb_mips_debug_dumper;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst, start, auto_en, halt, tx_ready;
  logic [95:0]  if_id, mem_wb;
  logic [159:0] id_ex;
  logic [127:0] ex_mem;
  logic [31:0]  reg_data, mem_data;
  logic         debug_flag, tx_valid, busy, done;
  logic [3:0]   addr_reg;
  logic [2:0]   addr_mem;
  logic [7:0]   tx_data;

  always #5 clk = ~clk;

  mips_debug_dumper #(.RD_LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_auto_en(auto_en),
    .i_halt(halt), .i_if_id(if_id), .i_id_ex(id_ex), .i_ex_mem(ex_mem),
    .i_mem_wb(mem_wb), .i_reg_data(reg_data), .i_mem_data(mem_data),
    .o_debug_flag(debug_flag), .o_addr_reg(addr_reg), .o_addr_mem(addr_mem),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done)
  );

  // Recolector model: read data follows the address after LAT cycles.
  logic [31:0] regs [16];
  logic [31:0] mems [8];
  logic [3:0]  ra1, ra2;
  logic [2:0]  ma1, ma2;
  always @(posedge clk) begin
    ra1 <= addr_reg; ra2 <= ra1;
    ma1 <= addr_mem; ma2 <= ma1;
  end
  assign reg_data = regs[ra2];
  assign mem_data = mems[ma2];

  int total = 0, bad = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx [256];
  int idx = 0, frame_len = 0, done_cnt = 0, cyc = 0, last_cyc = 0;
  bit stall_prev = 0, rnd = 0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_buses();
    for (int i = 0; i < 3; i++) if_id[i*32 +: 32] = $urandom();
    for (int i = 0; i < 5; i++) id_ex[i*32 +: 32] = $urandom();
    for (int i = 0; i < 4; i++) ex_mem[i*32 +: 32] = $urandom();
    for (int i = 0; i < 3; i++) mem_wb[i*32 +: 32] = $urandom();
    if_id[95:64] = 32'h0000_0004;
  endtask

  // Expected frame from the bus values and recolector model contents.
  task automatic push_frame();
    logic [479:0] s;
    s = {if_id, id_ex, ex_mem, mem_wb};
    exp_q.push_back(8'hA5);
    for (int i = 59; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
    for (int r = 0; r < 16; r++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][b*8 +: 8]);
    for (int m = 0; m < 8; m++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(mems[m][b*8 +: 8]);
    exp_q.push_back(8'h5A);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    for (int k = 0; k < 4000 && done_cnt == prev; k++) tick();
    check("frame_done", done_cnt, prev + 1);
  endtask

  // Ready driver: constant 1, or pseudo-random stalls.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, stall_data);
      end
      if (tx_valid && tx_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL extra_byte observed=%0h expected=none", tx_data);
        end
        if (exp_q.size() != 0) check("frame_byte", tx_data, exp_q.pop_front());
        check("flag_in_xfer", debug_flag, (idx >= 61 && idx < 157));
        check("busy_in_xfer", busy, 1);
        if (idx < 256) rx[idx] = tx_data;
        idx++;
        last_cyc = cyc;
      end
      if (done) begin
        check("done_latency", cyc - last_cyc, 1);
        check("busy_at_done", busy, 0);
        frame_len = idx;
        idx = 0;
        done_cnt++;
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  initial begin
    int prev;
    rst = 1'b0; start = 1'b0; auto_en = 1'b0; halt = 1'b0;
    for (int r = 0; r < 16; r++) regs[r] = r * 32'h1111_1111;
    for (int m = 0; m < 8; m++) mems[m] = 32'hC0DE_0000 + m * 32'h0101;
    randomize_buses();
    repeat (3) tick();
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flag", debug_flag, 0);
    check("rst_addr_reg", addr_reg, 0);
    check("rst_addr_mem", addr_mem, 0);
    rst = 1'b1;
    tick();

    // Frame with ready always high; buses change after the snapshot.
    prev = done_cnt;
    pulse_start();
    tick(); tick();
    randomize_buses();
    wait_done(prev);
    check("len_ready1", frame_len, 158);
    check("byte0", rx[0], 8'hA5);
    check("byte1", rx[1], 8'h00);
    check("byte2", rx[2], 8'h00);
    check("byte3", rx[3], 8'h00);
    check("byte4", rx[4], 8'h04);
    for (int i = 73; i <= 76; i++) check("reg3_byte", rx[i], 8'h33);
    check("byte157", rx[157], 8'h5A);
    check("queue_empty1", exp_q.size(), 0);
    check("flag_idle", debug_flag, 0);

    // Random stalls, new memory contents.
    for (int m = 0; m < 8; m++) mems[m] = $urandom();
    rnd = 1;
    tick();
    prev = done_cnt;
    pulse_start();
    wait_done(prev);
    check("len_stall", frame_len, 158);
    check("queue_empty2", exp_q.size(), 0);
    rnd = 0;
    tick();

    // Start and halt edge together, then start mid-frame: one frame only.
    prev = done_cnt;
    auto_en = 1'b1;
    halt = 1'b1;
    pulse_start();
    for (int k = 0; k < 2000 && idx < 20; k++) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(prev);
    repeat (300) tick();
    check("single_frame", done_cnt, prev + 1);
    check("queue_empty3", exp_q.size(), 0);
    check("busy_after", busy, 0);

    // Halt rising edge alone with auto enabled.
    halt = 1'b0;
    tick(); tick();
    prev = done_cnt;
    halt = 1'b1;
    push_frame();
    tick();
    wait_done(prev);
    check("len_halt", frame_len, 158);

    // Halt rising edge with auto disabled: no frame.
    auto_en = 1'b0;
    halt = 1'b0;
    tick(); tick();
    prev = done_cnt;
    halt = 1'b1;
    repeat (300) tick();
    check("no_auto_frame", done_cnt, prev);
    check("no_auto_busy", busy, 0);
    halt = 1'b0;

    // Reset in the middle of the register section.
    pulse_start();
    for (int k = 0; k < 2000 && idx < 80; k++) tick();
    check("reached_byte80", (idx >= 80), 1);
    rst = 1'b0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_flag", debug_flag, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", tx_data, 0);
    exp_q.delete();
    idx = 0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    prev = done_cnt;
    pulse_start();
    wait_done(prev);
    check("len_after_rst", frame_len, 158);
    check("queue_empty4", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
